// File: rtl/buzzer_voice.sv
// Piezo buzzer voice: plays one note at a time as a PWM-gated square wave
// followed by a silent articulation gap.
module buzzer_voice #(
  parameter int PERIOD_W  = 20,
  parameter int DUR_W     = 24,
  parameter int GAP_TICKS = 625000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                note_valid,
  output logic                note_ready,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  input  logic [2:0]          volume,
  output logic                buzzer,
  output logic                busy,
  output logic                note_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [DUR_W:0] GAP_X = (DUR_W+1)'(GAP_TICKS);

  state_t              state, state_n;
  logic [DUR_W-1:0]    cyc, cyc_n;
  logic [DUR_W-1:0]    dur_q, dur_n;
  logic [DUR_W-1:0]    t_q, t_n;
  logic [PERIOD_W-1:0] per_q, per_n;
  logic [PERIOD_W-1:0] hp, hp_n;
  logic [2:0]          vol_q, vol_n;
  logic [2:0]          pwm, pwm_n;
  logic                phase, phase_n;
  logic                done_n, buz_n;
  logic [DUR_W:0]      tone_diff;

  // tone length saturates at zero when the note is shorter than the gap
  assign tone_diff = {1'b0, note_dur} - GAP_X;

  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_n = state;
    cyc_n   = cyc;
    dur_n   = dur_q;
    t_n     = t_q;
    per_n   = per_q;
    hp_n    = hp;
    vol_n   = vol_q;
    pwm_n   = pwm;
    phase_n = phase;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (note_valid) begin
          dur_n   = note_dur;
          per_n   = note_period;
          vol_n   = volume;
          t_n     = tone_diff[DUR_W] ? '0 : tone_diff[DUR_W-1:0];
          cyc_n   = {{(DUR_W-1){1'b0}}, 1'b1};
          hp_n    = '0;
          pwm_n   = '0;
          phase_n = 1'b1;
          if (note_dur == '0) begin
            done_n = 1'b1;
          end else if (t_n != '0) begin
            state_n = TONE;
          end else begin
            state_n = GAP;
          end
        end
      end
      TONE: begin
        pwm_n = pwm + 3'd1;
        if (hp == per_q - 1'b1) begin
          hp_n    = '0;
          phase_n = ~phase;
        end else begin
          hp_n = hp + 1'b1;
        end
        if (cyc == dur_q) begin
          state_n = IDLE;
        end else begin
          cyc_n = cyc + 1'b1;
          if (cyc == t_q) state_n = GAP;
        end
      end
      GAP: begin
        pwm_n = pwm + 3'd1;
        if (cyc == dur_q) state_n = IDLE;
        else cyc_n = cyc + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (state_n != IDLE && cyc_n == dur_n) done_n = 1'b1;
    buz_n = phase_n && (pwm_n <= vol_n) && (state_n == TONE)
            && (per_n != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      dur_q     <= '0;
      t_q       <= '0;
      per_q     <= '0;
      hp        <= '0;
      vol_q     <= '0;
      pwm       <= '0;
      phase     <= 1'b0;
      note_done <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      dur_q     <= dur_n;
      t_q       <= t_n;
      per_q     <= per_n;
      hp        <= hp_n;
      vol_q     <= vol_n;
      pwm       <= pwm_n;
      phase     <= phase_n;
      note_done <= done_n;
      buzzer    <= buz_n;
    end
  end

endmodule

// File: doc/buzzer_voice.md
BUZZER_VOICE -- requirements
Module: buzzer_voice

Interface
REQ-001 Parameter PERIOD_W, default 20: width of note_period.
REQ-002 Parameter DUR_W, default 24: width of note_dur.
REQ-003 Parameter GAP_TICKS, default 625000: silent articulation gap at the end of every note, in clk cycles (12.5 ms at 50 MHz).
REQ-004 clk  in  1  single clock, rising edge; the block SHALL use this clock only.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 note_valid  in  1  note offered by the upstream sequencer.
REQ-007 note_ready  out  1  block can accept a note.
REQ-008 note_period  in  PERIOD_W  half-period in clk cycles; 0 = rest.
REQ-009 note_dur  in  DUR_W  total note length in clk cycles, gap included.
REQ-010 volume  in  3  PWM level, 0 = 1/8 duty, 7 = full.
REQ-011 buzzer  out  1  gated square wave to the piezo.
REQ-012 busy  out  1  a note is in progress.
REQ-013 note_done  out  1  one-cycle pulse in the last cycle of each note.

Function
REQ-014 States SHALL be IDLE, TONE and GAP; note_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-015 Accept SHALL occur on an edge where note_valid && note_ready; note_period, note_dur and volume SHALL be latched at that edge, and inputs SHALL be ignored at all other times.
REQ-016 Call the accept edge cycle 0; the note SHALL occupy cycles 1..note_dur; note_done SHALL be high in cycle note_dur only; state SHALL be IDLE in cycle note_dur+1.
REQ-017 Tone length T SHALL be note_dur-GAP_TICKS, saturating at 0; cycles 1..T SHALL be TONE and cycles T+1..note_dur SHALL be GAP.
REQ-018 The transition from IDLE on accept SHALL go to TONE if T>0, otherwise to GAP; TONE SHALL go to GAP after T cycles; GAP SHALL go to IDLE after its last cycle.
REQ-019 If note_dur==0, the block SHALL accept the note, stay in IDLE, and pulse note_done in cycle 1; buzzer SHALL stay 0.
REQ-020 Phase SHALL be forced to 1 and the half-period counter cleared on every accept.
REQ-021 In TONE, the half-period counter SHALL increment each cycle; when it equals note_period-1, it SHALL clear and phase SHALL toggle. Phase is therefore 1 for cycles 1..P, 0 for cycles P+1..2P, and so on.
REQ-022 The 3-bit PWM counter SHALL clear on accept and increment (wrapping) each cycle while busy; pwm_on SHALL be (pwm_cnt <= volume latched).
REQ-023 buzzer SHALL be registered and equal phase && pwm_on && state==TONE && period!=0; it SHALL be 0 in IDLE, in GAP and for rests.
REQ-024 Duration and half-period counters SHALL be full width; there SHALL be no overflow for any legal input, including period=2^PERIOD_W-1 and note_dur=2^DUR_W-1.
REQ-025 A back-to-back note MAY be accepted at the edge ending cycle note_dur+1; the minimum inter-note spacing SHALL be one IDLE cycle.

Reset
REQ-026 While rst is high, the block SHALL be in IDLE with buzzer=0, busy=0, note_done=0 and note_ready=1; all counters, phase and latched fields SHALL be 0.
REQ-027 rst asserted mid-note SHALL abort the note immediately, without a note_done pulse; the first accept after release SHALL start a fresh note.

Verification (GAP_TICKS=4 in simulation)
REQ-028 period=3, dur=20, vol=7 -> buzzer 1 in cycles 1-3, 0 in 4-6, 1 in 7-9, 0 in 10-12, 1 in 13-15, 0 in 16; 0 in 17-20; note_done in cycle 20; ready in cycle 21.
REQ-029 period=0, dur=10 -> buzzer 0 throughout, busy in cycles 1-10, note_done in cycle 10.
REQ-030 dur=0 -> note_done in cycle 1, busy never asserted; dur=3 -> silent GAP in cycles 1-3, note_done in cycle 3.
REQ-031 period=8, vol=0, dur=24 -> buzzer 1 only in cycles 1 and 17 (pwm_cnt=0 while phase=1).
REQ-032 note_valid held high with two queued notes (dur=6, dur=6) -> accepts at cycle 0 and cycle 7, note_done in cycles 6 and 13.
REQ-033 rst pulsed in cycle 5 of a period=2, dur=20 note -> buzzer and busy go to 0 asynchronously, no note_done, ready=1 during reset.
